// File: rtl/se_conv_sequencer.sv
// Sequencer for one serial pointwise Conv2D inside the SE layer: weight load, pixel feed, result FIFO.
// Optional watchdog and ERR state enabled by defining SEQ_TIMEOUT_EN.
module se_conv_sequencer #(
   parameter int DATA_WIDTH     = 16,
   parameter int IN_CHANNELS    = 2,
   parameter int OUT_CHANNELS   = 1,
   parameter int SETTLE_CYCLES  = 2,
   parameter int FIFO_DEPTH     = 4,
   parameter int TIMEOUT_CYCLES = 64,
   localparam int K  = IN_CHANNELS * OUT_CHANNELS,
   localparam int AW = (K > 1) ? $clog2(K) : 1
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_start,
   input  logic [15:0]           i_num_pixels,
   output logic                  o_busy,
   output logic                  o_done,
   output logic                  o_err,
   output logic                  o_w_rd_en,
   output logic [AW-1:0]         o_w_addr,
   input  logic [DATA_WIDTH-1:0] i_w_rdata,
   input  logic [DATA_WIDTH-1:0] i_s_data,
   input  logic                  i_s_valid,
   output logic                  o_s_ready,
   output logic                  o_conv_load_kernel,
   output logic                  o_conv_in_valid,
   output logic [DATA_WIDTH-1:0] o_conv_in_data,
   input  logic [DATA_WIDTH-1:0] i_conv_out_data,
   input  logic                  i_conv_out_valid,
   output logic [DATA_WIDTH-1:0] o_m_data,
   output logic                  o_m_valid,
   input  logic                  i_m_ready
);
   localparam int LW = $clog2(K + 1);
   localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
   localparam int IW = $clog2(IN_CHANNELS + 1);
   localparam int OW = $clog2(OUT_CHANNELS + 1);
   localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW = $clog2(FIFO_DEPTH + 1);

   localparam logic [2:0] S_IDLE     = 3'd0;
   localparam logic [2:0] S_LOAD_W   = 3'd1;
   localparam logic [2:0] S_SETTLE   = 3'd2;
   localparam logic [2:0] S_FEED     = 3'd3;
   localparam logic [2:0] S_WAIT_OUT = 3'd4;
   localparam logic [2:0] S_DONE     = 3'd5;
`ifdef SEQ_TIMEOUT_EN
   localparam logic [2:0] S_ERR      = 3'd6;
   localparam int         WW         = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   logic [WW-1:0]         r_wd_cnt;
`endif

   logic [2:0]            r_state;
   logic [15:0]           r_num_pixels;
   logic [15:0]           r_pix_cnt;
   logic [LW-1:0]         r_ld_cnt;
   logic [SW-1:0]         r_settle_cnt;
   logic [IW-1:0]         r_in_cnt;
   logic [OW-1:0]         r_out_cnt;
   logic                  r_err;
   logic                  r_w_rd_en;
   logic [AW-1:0]         r_w_addr;
   logic                  r_load;
   logic                  r_in_valid;
   logic [DATA_WIDTH-1:0] r_in_data;

   logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
   logic [PW-1:0]         r_wr_ptr;
   logic [PW-1:0]         r_rd_ptr;
   logic [CW-1:0]         r_count;

   logic w_accept_state;
   logic w_pop;
   logic w_full;
   logic w_push;
   logic w_drop;
   logic w_handshake;
   int   w_free;

   assign w_accept_state = (r_state == S_FEED) || (r_state == S_WAIT_OUT);
   assign w_pop          = (r_count != '0) && i_m_ready;
   assign w_full         = (int'(r_count) == FIFO_DEPTH);
   assign w_push         = i_conv_out_valid && w_accept_state && (!w_full || w_pop);
   assign w_drop         = i_conv_out_valid && !(w_accept_state && (!w_full || w_pop));
   assign w_free         = FIFO_DEPTH - int'(r_count) + (w_pop ? 1 : 0);
   assign w_handshake    = i_s_valid && o_s_ready;

   assign o_busy             = (r_state != S_IDLE);
   assign o_done             = (r_state == S_DONE);
   assign o_err              = r_err;
   assign o_w_rd_en          = r_w_rd_en;
   assign o_w_addr           = r_w_addr;
   assign o_s_ready          = (r_state == S_FEED) && (int'(r_in_cnt) < IN_CHANNELS);
   assign o_conv_load_kernel = r_load;
   assign o_conv_in_valid    = r_in_valid;
   // ROM data arrives one cycle after the read, so load beats forward it straight through.
   assign o_conv_in_data     = r_load ? i_w_rdata : r_in_data;
   assign o_m_data           = r_mem[r_rd_ptr];
   assign o_m_valid          = (r_count != '0);

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
      end else begin
         if (w_push) begin
            r_mem[r_wr_ptr] <= i_conv_out_data;
            r_wr_ptr <= (int'(r_wr_ptr) == FIFO_DEPTH - 1) ? '0 : r_wr_ptr + 1'b1;
         end
         if (w_pop) r_rd_ptr <= (int'(r_rd_ptr) == FIFO_DEPTH - 1) ? '0 : r_rd_ptr + 1'b1;
         r_count <= r_count + CW'(w_push) - CW'(w_pop);
      end
   end

   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         r_state      <= S_IDLE;
         r_num_pixels <= '0;
         r_pix_cnt    <= '0;
         r_ld_cnt     <= '0;
         r_settle_cnt <= '0;
         r_in_cnt     <= '0;
         r_out_cnt    <= '0;
         r_err        <= 1'b0;
         r_w_rd_en    <= 1'b0;
         r_w_addr     <= '0;
         r_load       <= 1'b0;
         r_in_valid   <= 1'b0;
         r_in_data    <= '0;
`ifdef SEQ_TIMEOUT_EN
         r_wd_cnt     <= '0;
`endif
      end else begin
         r_in_valid <= 1'b0;
         r_load     <= r_w_rd_en;
         if (w_drop) r_err <= 1'b1;
         if (w_accept_state && i_conv_out_valid && int'(r_out_cnt) < OUT_CHANNELS)
            r_out_cnt <= r_out_cnt + 1'b1;
         case (r_state)
            S_IDLE: begin
               if (i_start) begin
                  r_num_pixels <= i_num_pixels;
                  r_err        <= w_drop;
                  r_pix_cnt    <= '0;
                  r_in_cnt     <= '0;
                  r_out_cnt    <= '0;
                  if (i_num_pixels == 16'd0) begin
                     r_state <= S_DONE;
                  end else begin
                     r_state   <= S_LOAD_W;
                     r_w_rd_en <= 1'b1;
                     r_w_addr  <= '0;
                     r_ld_cnt  <= '0;
                  end
               end
            end
            S_LOAD_W: begin
               r_ld_cnt <= r_ld_cnt + 1'b1;
               if (int'(r_ld_cnt) + 1 < K) begin
                  r_w_rd_en <= 1'b1;
                  r_w_addr  <= AW'(int'(r_ld_cnt) + 1);
               end else begin
                  r_w_rd_en <= 1'b0;
                  r_w_addr  <= '0;
               end
               if (int'(r_ld_cnt) == K) begin
                  r_state      <= S_SETTLE;
                  r_settle_cnt <= '0;
               end
            end
            S_SETTLE: begin
               if (int'(r_settle_cnt) + 1 >= SETTLE_CYCLES) r_state <= S_FEED;
               else r_settle_cnt <= r_settle_cnt + 1'b1;
            end
            S_FEED: begin
               if (w_handshake) begin
                  r_in_valid <= 1'b1;
                  r_in_data  <= i_s_data;
                  r_in_cnt   <= r_in_cnt + 1'b1;
                  if (int'(r_in_cnt) + 1 == IN_CHANNELS) begin
                     r_state <= S_WAIT_OUT;
`ifdef SEQ_TIMEOUT_EN
                     r_wd_cnt <= '0;
`endif
                  end
               end
            end
            S_WAIT_OUT: begin
               if (int'(r_out_cnt) == OUT_CHANNELS) begin
                  if (({1'b0, r_pix_cnt} + 17'd1) < {1'b0, r_num_pixels}) begin
                     if (w_free >= OUT_CHANNELS) begin
                        r_pix_cnt <= r_pix_cnt + 16'd1;
                        r_in_cnt  <= '0;
                        r_out_cnt <= '0;
                        r_state   <= S_FEED;
                     end
                  end else begin
                     r_state <= S_DONE;
                  end
               end
`ifdef SEQ_TIMEOUT_EN
               // Only time the wait for conv results; FIFO backpressure stalls are legitimate.
               else if (i_conv_out_valid) r_wd_cnt <= '0;
               else if (int'(r_wd_cnt) == TIMEOUT_CYCLES - 1) begin
                  r_state <= S_ERR;
                  r_err   <= 1'b1;
               end else r_wd_cnt <= r_wd_cnt + 1'b1;
`endif
            end
            S_DONE: r_state <= S_IDLE;
`ifdef SEQ_TIMEOUT_EN
            S_ERR: r_state <= S_ERR;
`endif
            default: r_state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_se_conv_sequencer.sv
// Directed bench for se_conv_sequencer with a behavioural weight ROM and a 2x1 pointwise conv stub.
// Exercises the SEQ_TIMEOUT_EN watchdog when that macro is defined, otherwise the indefinite wait.
module tb_se_conv_sequencer;
   localparam int DW    = 16;
   localparam int INC   = 2;
   localparam int OUTC  = 1;
   localparam int DEPTH = 2;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          start = 1'b0;
   logic [15:0]   numPixels = '0;
   logic          busy, done, err;
   logic          wRdEn;
   logic [0:0]    wAddr;
   logic [DW-1:0] wRdata = '0;
   logic [DW-1:0] sData = '0;
   logic          sValid = 1'b0;
   logic          sReady;
   logic          convLoad, convInValid;
   logic [DW-1:0] convInData;
   logic [DW-1:0] convOutData;
   logic          convOutValid;
   logic [DW-1:0] mData;
   logic          mValid;
   logic          mReady = 1'b1;
   logic          convMute = 1'b0;

   logic [15:0]   rom [0:1] = '{16'd2, 16'd3};
   logic [15:0]   kern [0:1];
   logic          kIdx, xIdx;
   logic [15:0]   acc, odPipe0, odPipe1;
   logic [1:0]    ovPipe;

   int assertCount = 0;
   int failCount   = 0;

   logic [15:0] loadQ [$];
   logic [15:0] outQ  [$];
   int inValidCnt = 0, doneCnt = 0, rdCnt = 0, overlapCnt = 0, convOutCnt = 0, convOutAtDone = 0;

   always #5 clk = ~clk;

   se_conv_sequencer #(
      .DATA_WIDTH(DW), .IN_CHANNELS(INC), .OUT_CHANNELS(OUTC),
      .SETTLE_CYCLES(2), .FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(64)
   ) dut (
      .i_clk(clk), .i_rst(rst), .i_start(start), .i_num_pixels(numPixels),
      .o_busy(busy), .o_done(done), .o_err(err),
      .o_w_rd_en(wRdEn), .o_w_addr(wAddr), .i_w_rdata(wRdata),
      .i_s_data(sData), .i_s_valid(sValid), .o_s_ready(sReady),
      .o_conv_load_kernel(convLoad), .o_conv_in_valid(convInValid), .o_conv_in_data(convInData),
      .i_conv_out_data(convOutData), .i_conv_out_valid(convOutValid),
      .o_m_data(mData), .o_m_valid(mValid), .i_m_ready(mReady)
   );

   // Weight ROM with one cycle read latency
   always @(posedge clk) if (wRdEn) wRdata <= rom[wAddr];

   // Conv stub: out = k0*x0 + k1*x1, result emerges two cycles after the second input
   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         kIdx <= 1'b0; xIdx <= 1'b0; acc <= '0; ovPipe <= '0;
         odPipe0 <= '0; odPipe1 <= '0; kern[0] <= '0; kern[1] <= '0;
      end else begin
         ovPipe  <= {ovPipe[0], 1'b0};
         odPipe1 <= odPipe0;
         if (convLoad) begin
            kern[kIdx] <= convInData;
            kIdx <= ~kIdx;
         end
         if (convInValid) begin
            if (xIdx) begin
               ovPipe[0] <= 1'b1;
               odPipe0   <= acc + kern[1] * convInData;
               acc       <= '0;
               xIdx      <= 1'b0;
            end else begin
               acc  <= kern[0] * convInData;
               xIdx <= 1'b1;
            end
         end
      end
   end
   assign convOutValid = ovPipe[1] & ~convMute;
   assign convOutData  = odPipe1;

   // Passive monitor sampling on the falling edge
   always @(negedge clk) begin
      if (rst) begin
         if (convLoad) loadQ.push_back(convInData);
         if (mValid && mReady) outQ.push_back(mData);
         if (convInValid) inValidCnt <= inValidCnt + 1;
         if (wRdEn) rdCnt <= rdCnt + 1;
         if (convLoad && convInValid) overlapCnt <= overlapCnt + 1;
         if (convOutValid) convOutCnt <= convOutCnt + 1;
         if (done) begin
            doneCnt <= doneCnt + 1;
            convOutAtDone <= convOutCnt;
         end
      end
   end

   initial begin
      #500000;
      $display("[TB] FAIL global time limit reached");
      $fatal(1, "[TB] time limit");
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      assertCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic [15:0] num);
      @(posedge clk); #1;
      start = 1'b1;
      numPixels = num;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic sendBeat(input string tag, input logic [15:0] d);
      logic ok;
      ok = 1'b0;
      sValid = 1'b1;
      sData = d;
      for (int i = 0; i < 200 && !ok; i++) begin
         @(negedge clk);
         if (sReady) begin
            @(posedge clk); #1;
            ok = 1'b1;
         end
      end
      sValid = 1'b0;
      checkOutput(tag, 32'(ok), 32'd1);
   endtask

   task automatic sendPixel(input string tag, input logic [15:0] a, input logic [15:0] b, input int gap);
      sendBeat(tag, a);
      repeat (gap) begin @(posedge clk); #1; end
      sendBeat(tag, b);
   endtask

   task automatic waitDone(input string tag, input int maxCycles);
      logic seen;
      seen = 1'b0;
      for (int i = 0; i < maxCycles && !seen; i++) begin
         @(negedge clk);
         if (done) seen = 1'b1;
      end
      checkOutput(tag, 32'(seen), 32'd1);
      @(posedge clk); #1;
   endtask

   task automatic waitMValid(input string tag, input int maxCycles);
      logic seen;
      seen = 1'b0;
      for (int i = 0; i < maxCycles && !seen; i++) begin
         @(negedge clk);
         if (mValid) seen = 1'b1;
      end
      checkOutput(tag, 32'(seen), 32'd1);
   endtask

   initial begin
      int outBase, loadBase, inBase, doneBase, rdBase, convBase;

      // Reset state
      rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      checkOutput("reset busy", 32'(busy), 0);
      checkOutput("reset done", 32'(done), 0);
      checkOutput("reset err", 32'(err), 0);
      checkOutput("reset m_valid", 32'(mValid), 0);
      checkOutput("reset s_ready", 32'(sReady), 0);
      checkOutput("reset w_rd_en", 32'(wRdEn), 0);
      checkOutput("reset load_kernel", 32'(convLoad), 0);
      checkOutput("reset in_valid", 32'(convInValid), 0);
      @(negedge clk);
      rst = 1'b1;

      // Single pixel: weights 2,3 and stream 5,7 -> 31
      outBase = outQ.size(); loadBase = loadQ.size(); doneBase = doneCnt; rdBase = rdCnt;
      applyStimulus(16'd1);
      checkOutput("busy after start", 32'(busy), 1);
      sendPixel("t1 pixel", 16'd5, 16'd7, 0);
      waitDone("t1 done", 100);
      repeat (4) @(posedge clk);
      #1;
      checkOutput("t1 load beats", 32'(loadQ.size() - loadBase), 2);
      if (loadQ.size() - loadBase == 2) begin
         checkOutput("t1 load beat0", 32'(loadQ[loadBase]), 2);
         checkOutput("t1 load beat1", 32'(loadQ[loadBase + 1]), 3);
      end
      checkOutput("t1 rom reads", 32'(rdCnt - rdBase), 2);
      checkOutput("t1 outputs", 32'(outQ.size() - outBase), 1);
      if (outQ.size() - outBase == 1) checkOutput("t1 m_data", 32'(outQ[outBase]), 31);
      checkOutput("t1 done pulses", 32'(doneCnt - doneBase), 1);
      checkOutput("t1 err", 32'(err), 0);
      checkOutput("t1 idle", 32'(busy), 0);

      // Three pixels with a gap inside one pair
      outBase = outQ.size(); inBase = inValidCnt; doneBase = doneCnt; convBase = convOutCnt;
      applyStimulus(16'd3);
      sendPixel("t2 pixel0", 16'd5, 16'd7, 0);
      sendPixel("t2 pixel1", 16'd1, 16'd1, 3);
      sendPixel("t2 pixel2", 16'd0, 16'd4, 1);
      waitDone("t2 done", 100);
      checkOutput("t2 results before done", 32'(convOutAtDone - convBase), 3);
      repeat (4) @(posedge clk);
      #1;
      checkOutput("t2 in_valid beats", 32'(inValidCnt - inBase), 6);
      checkOutput("t2 outputs", 32'(outQ.size() - outBase), 3);
      if (outQ.size() - outBase == 3) begin
         checkOutput("t2 m_data0", 32'(outQ[outBase]), 31);
         checkOutput("t2 m_data1", 32'(outQ[outBase + 1]), 5);
         checkOutput("t2 m_data2", 32'(outQ[outBase + 2]), 12);
      end
      checkOutput("t2 done pulses", 32'(doneCnt - doneBase), 1);

      // Backpressure: depth-2 FIFO fills and FEED stalls
      outBase = outQ.size(); doneBase = doneCnt;
      mReady = 1'b0;
      applyStimulus(16'd3);
      sendPixel("t3 pixel0", 16'd5, 16'd7, 0);
      sendPixel("t3 pixel1", 16'd1, 16'd1, 0);
      repeat (20) @(posedge clk);
      #1;
      checkOutput("t3 stalled s_ready", 32'(sReady), 0);
      checkOutput("t3 stalled busy", 32'(busy), 1);
      checkOutput("t3 stalled m_valid", 32'(mValid), 1);
      checkOutput("t3 held m_data", 32'(mData), 31);
      checkOutput("t3 nothing popped", 32'(outQ.size() - outBase), 0);
      mReady = 1'b1;
      sendPixel("t3 pixel2", 16'd0, 16'd4, 0);
      waitDone("t3 done", 100);
      repeat (4) @(posedge clk);
      #1;
      checkOutput("t3 outputs", 32'(outQ.size() - outBase), 3);
      if (outQ.size() - outBase == 3) begin
         checkOutput("t3 m_data0", 32'(outQ[outBase]), 31);
         checkOutput("t3 m_data1", 32'(outQ[outBase + 1]), 5);
         checkOutput("t3 m_data2", 32'(outQ[outBase + 2]), 12);
      end
      checkOutput("t3 err", 32'(err), 0);

      // Zero pixels: straight to DONE without weight reads
      rdBase = rdCnt; doneBase = doneCnt;
      applyStimulus(16'd0);
      checkOutput("t4 zero done pulse", 32'(done), 1);
      @(posedge clk); #1;
      checkOutput("t4 zero done cleared", 32'(done), 0);
      checkOutput("t4 zero idle", 32'(busy), 0);
      checkOutput("t4 zero rom reads", 32'(rdCnt - rdBase), 0);

      // Start while busy is ignored
      outBase = outQ.size(); doneBase = doneCnt;
      applyStimulus(16'd1);
      applyStimulus(16'd5);
      sendPixel("t4 pixel", 16'd5, 16'd7, 0);
      waitDone("t4 done", 100);
      repeat (6) @(posedge clk);
      #1;
      checkOutput("t4 outputs", 32'(outQ.size() - outBase), 1);
      if (outQ.size() - outBase == 1) checkOutput("t4 m_data", 32'(outQ[outBase]), 31);
      checkOutput("t4 done pulses", 32'(doneCnt - doneBase), 1);
      checkOutput("t4 idle after", 32'(busy), 0);
      checkOutput("t4 s_ready after", 32'(sReady), 0);

      // Reset during FEED with a result waiting in the FIFO
      doneBase = doneCnt;
      mReady = 1'b0;
      applyStimulus(16'd2);
      sendPixel("t5 pixel0", 16'd5, 16'd7, 0);
      waitMValid("t5 first result", 50);
      sendBeat("t5 half pixel", 16'd1);
      #3;
      rst = 1'b0;
      #1;
      checkOutput("t5 rst busy", 32'(busy), 0);
      checkOutput("t5 rst s_ready", 32'(sReady), 0);
      checkOutput("t5 rst m_valid", 32'(mValid), 0);
      checkOutput("t5 rst m_data", 32'(mData), 0);
      checkOutput("t5 rst in_valid", 32'(convInValid), 0);
      checkOutput("t5 rst in_data", 32'(convInData), 0);
      checkOutput("t5 rst done", 32'(done), 0);
      checkOutput("t5 rst err", 32'(err), 0);
      @(negedge clk);
      rst = 1'b1;
      mReady = 1'b1;
      checkOutput("t5 no done pulse", 32'(doneCnt - doneBase), 0);
      outBase = outQ.size();
      applyStimulus(16'd1);
      sendPixel("t5 fresh pixel", 16'd5, 16'd7, 0);
      waitDone("t5 fresh done", 100);
      repeat (4) @(posedge clk);
      #1;
      checkOutput("t5 fresh outputs", 32'(outQ.size() - outBase), 1);
      if (outQ.size() - outBase == 1) checkOutput("t5 fresh m_data", 32'(outQ[outBase]), 31);

      // Conv never answers
      doneBase = doneCnt;
      convMute = 1'b1;
      applyStimulus(16'd1);
      sendPixel("t6 pixel", 16'd5, 16'd7, 0);
`ifdef SEQ_TIMEOUT_EN
      repeat (40) @(posedge clk);
      #1;
      checkOutput("t6 err before limit", 32'(err), 0);
      repeat (40) @(posedge clk);
      #1;
      checkOutput("t6 err after limit", 32'(err), 1);
      checkOutput("t6 err busy", 32'(busy), 1);
      checkOutput("t6 err s_ready", 32'(sReady), 0);
      convMute = 1'b0;
      repeat (20) @(posedge clk);
      #1;
      checkOutput("t6 stuck busy", 32'(busy), 1);
      checkOutput("t6 stuck err", 32'(err), 1);
`else
      repeat (120) @(posedge clk);
      #1;
      checkOutput("t6 waiting busy", 32'(busy), 1);
      checkOutput("t6 waiting err", 32'(err), 0);
      checkOutput("t6 waiting s_ready", 32'(sReady), 0);
`endif
      checkOutput("t6 no done", 32'(doneCnt - doneBase), 0);
      rst = 1'b0;
      #1;
      checkOutput("t6 reset busy", 32'(busy), 0);
      checkOutput("t6 reset err", 32'(err), 0);
      convMute = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      repeat (2) @(posedge clk);

      checkOutput("load never with in_valid", 32'(overlapCnt), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end
endmodule

// File: doc/se_conv_sequencer.md
Name: se_conv_sequencer

Overview:
- Sequences one serial pointwise Conv2D instance (DATA_WIDTH 16, IN_CHANNELS x OUT_CHANNELS) inside the SE layer.
- On start, streams IN_CHANNELS*OUT_CHANNELS kernel weights from a weight ROM into the conv. It then feeds num_pixels channel vectors from an upstream stream.
- Collects OUT_CHANNELS results per pixel into an output FIFO with valid/ready backpressure toward the next SE stage.

Parameters:
- DATA_WIDTH, 16, width of weights, activations and results.
- IN_CHANNELS, 2, inputs per pixel.
- OUT_CHANNELS, 1, outputs per pixel.
- SETTLE_CYCLES, 2, idle cycles between the last weight load and the first in_valid (conv state change).
- FIFO_DEPTH, 4, output FIFO entries; must be >= OUT_CHANNELS.
- TIMEOUT_CYCLES, 64, watchdog limit (SEQ_TIMEOUT_EN only).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; ignored unless IDLE.
- num_pixels  in  16  pixel count, latched on accepted start.
- busy  out  1  high in any state except IDLE.
- done  out  1  one-cycle pulse at job end.
- err  out  1  sticky error; cleared by reset or accepted start.
- w_rd_en  out  1  weight ROM read strobe.
- w_addr  out  $clog2(IN_CHANNELS*OUT_CHANNELS)  ROM address.
- w_rdata  in  DATA_WIDTH  ROM data, valid 1 cycle after w_rd_en.
- s_data  in  DATA_WIDTH  upstream activation.
- s_valid  in  1  upstream valid.
- s_ready  out  1  upstream ready.
- conv_load_kernel  out  1  to Conv2D load_kernel.
- conv_in_valid  out  1  to Conv2D in_valid.
- conv_in_data  out  DATA_WIDTH  to Conv2D in_data.
- conv_out_data  in  DATA_WIDTH  from Conv2D out_data.
- conv_out_valid  in  1  from Conv2D out_valid.
- m_data  out  DATA_WIDTH  result; FIFO head.
- m_valid  out  1  FIFO non-empty.
- m_ready  in  1  downstream ready.

Behaviour:
- Reset (rst low, asynchronous):
  - All outputs 0; FSM to IDLE.
  - FIFO emptied; all counters cleared.
  - Reset mid-job abandons the job with no done pulse. Conv2D is reset by the same rst net.
- States: IDLE, LOAD_W, SETTLE, FEED, WAIT_OUT, DONE, plus ERR when SEQ_TIMEOUT_EN is defined.
- IDLE:
  - start latches num_pixels and clears err.
  - num_pixels==0: go to DONE, with no weight load.
  - Otherwise go to LOAD_W.
- LOAD_W:
  - w_rd_en=1 with w_addr = 0..K-1 on consecutive cycles, where K = IN_CHANNELS*OUT_CHANNELS.
  - One cycle after each read: conv_load_kernel=1 and conv_in_data=w_rdata.
  - Load lasts K+1 cycles; conv_load_kernel is never asserted together with conv_in_valid.
  - After the last load beat, go to SETTLE.
- SETTLE: counts SETTLE_CYCLES cycles, then goes to FEED.
- FEED:
  - s_ready=1 while in_cnt<IN_CHANNELS.
  - A handshake (s_valid & s_ready) registers conv_in_valid=1 and conv_in_data=s_data on the next cycle; in_cnt increments.
  - Gaps in s_valid produce gaps in conv_in_valid.
  - When in_cnt reaches IN_CHANNELS: s_ready=0 and go to WAIT_OUT.
- Output capture:
  - conv_out_valid is accepted in FEED and WAIT_OUT; each beat pushes to the FIFO and increments out_cnt.
  - A beat while the FIFO is full is dropped and sets err.
  - A beat in any other state is ignored and sets err.
- WAIT_OUT:
  - Waits until out_cnt==OUT_CHANNELS.
  - If pix_cnt+1 < num_pixels: wait until FIFO free slots >= OUT_CHANNELS, then increment pix_cnt, clear in_cnt and out_cnt, and go to FEED.
  - Otherwise go to DONE.
  - Free slots are counted including a same-cycle pop.
- DONE: done=1 for one cycle, then IDLE. The FIFO keeps draining after done.
- FIFO:
  - Push and pop in the same cycle are both honoured, including when full.
  - m_valid and m_data reflect the head registered state; m_data holds while m_valid & !m_ready.
  - Pointers wrap modulo FIFO_DEPTH.
- Width rules: counters are sized to their maxima; pix_cnt is 16 bits. No arithmetic is performed on data; values pass through unchanged.

Optional Feature:
- Macro SEQ_TIMEOUT_EN.
- Defined: a watchdog counts cycles spent in WAIT_OUT without conv_out_valid. Reaching TIMEOUT_CYCLES sets err and enters ERR. ERR holds busy=1 and s_ready=0, and exits to IDLE only on reset.
- Undefined: no watchdog, no ERR state; WAIT_OUT waits indefinitely.

Test Plan:
- IN=2, OUT=1, ROM {2,3}, num_pixels=1, stream 5,7, m_ready=1 -> load beats 2,3; one m_data=31; one done pulse; err=0.
- num_pixels=3, streams (5,7),(1,1),(0,4) -> m_data 31,5,12 in order; exactly 3 conv_in_valid pairs; done after the third.
- Same as the previous case with m_ready=0 until done and FIFO_DEPTH=2 -> FEED stalls after 2 results with s_ready=0. Releasing m_ready drains 31,5, then 12 is produced.
- start with num_pixels=0 -> no w_rd_en, done pulse 1 cycle later; start pulse while busy -> ignored, latched count unchanged.
- rst low during FEED -> all outputs 0 immediately, FIFO empty. A fresh start then completes with the correct 31.
- SEQ_TIMEOUT_EN, conv_out_valid held 0 -> err=1 after 64 WAIT_OUT cycles; FSM stuck in ERR until reset.
